// File: rtl/gpio_host_seq_pkg.sv
// Shared GPIO host definitions: op codes, GPIO word field positions, FSM states.
// Also used by ControlBlock so both sides agree on the GPIO word layout.
package gpio_host_seq_pkg;

    localparam int CTRL_MSB  = 31;
    localparam int CTRL_LSB  = 29;
    localparam int VALID_BIT = 28;
    localparam int DATA_MSB  = 24;
    localparam int DATA_LSB  = 1;
    localparam int RST_BIT   = 0;
    localparam int CNT_W     = 20;

    typedef enum logic [2:0] {
        OP_KERNEL   = 3'd0,
        OP_IMG_SIZE = 3'd1,
        OP_IMAGE    = 3'd2,
        OP_DATA_REQ = 3'd3,
        OP_RUN      = 3'd4,
        OP_DUT_RST  = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_GAP,
        ST_RD_WAIT,
        ST_RUN_WAIT,
        ST_RST_PULSE
    } state_e;

    function automatic logic [31:0] gpio_word(input logic [2:0] ctrl, input logic valid,
                                              input logic [23:0] data);
        logic [31:0] w;
        w                     = '0;
        w[CTRL_MSB:CTRL_LSB]  = ctrl;
        w[VALID_BIT]          = valid;
        w[DATA_MSB:DATA_LSB]  = data;
        return w;
    endfunction

endpackage

// File: rtl/gpio_host_seq_if.sv
// Host-side command / readback / status bundle of the GPIO sequencer.
interface gpio_host_seq_if #(
    parameter int BITS_DATA = 13
);
    logic                 i_cmd_valid;
    logic [2:0]           i_cmd_op;
    logic [23:0]          i_cmd_data;
    logic                 o_cmd_ready;
    logic [BITS_DATA-1:0] o_rd_data;
    logic                 o_rd_valid;
    logic                 o_eop_seen;
    logic                 o_err;
    logic                 o_busy;

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_data,
        input  o_cmd_ready, o_rd_data, o_rd_valid, o_eop_seen, o_err, o_busy
    );

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_data,
        output o_cmd_ready, o_rd_data, o_rd_valid, o_eop_seen, o_err, o_busy
    );
endinterface

// File: rtl/gpio_host_seq.sv
// Sequences host commands into strobed GPIO words for the DUT, reads data back,
// waits for end-of-process on RUN and pulses the DUT reset line.
module gpio_host_seq
    import gpio_host_seq_pkg::*;
#(
    parameter int GPIO_D    = 32,
    parameter int BITS_DATA = 13,
    parameter int HOLD      = 2,
    parameter int READ_LAT  = 3,
    parameter int RST_CYC   = 4,
    parameter int TIMEOUT   = 1048576
) (
    input  logic              i_CLK,
    input  logic              i_rst,
    gpio_host_seq_if.slave    host,
    output logic [GPIO_D-1:0] o_gpio,
    input  logic [GPIO_D-1:0] i_gpio,
    input  logic              i_eop
);

    // Counter loads are N-1: a phase of N cycles ends on the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] RD_LD      = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] RST_LD     = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT - 1);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GPIO_D-1:0]    gpio_q, gpio_d;
    logic [BITS_DATA-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 eop_seen_q, eop_seen_d;
    logic                 err_q, err_d;
    logic                 eop_prev_q, eop_prev_d;
    logic                 cmd_ready, cnt_zero, eop_rise;
    logic                 unused_gpio_hi;

    assign cmd_ready      = (state_q == ST_IDLE) && !i_rst;
    assign cnt_zero       = (cnt_q == '0);
    assign eop_rise       = i_eop && !eop_prev_q;
    assign unused_gpio_hi = ^i_gpio[GPIO_D-1:BITS_DATA];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        gpio_d     = gpio_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        eop_seen_d = 1'b0;
        err_d      = 1'b0;
        // Tracking the level every cycle means a level already high on RUN_WAIT entry is no edge.
        eop_prev_d = i_eop;

        unique case (state_q)
            ST_IDLE: begin
                gpio_d[RST_BIT] = 1'b0;
                if (host.i_cmd_valid && cmd_ready) begin
                    case (host.i_cmd_op)
                        OP_KERNEL, OP_IMG_SIZE, OP_IMAGE: begin
                            op_d    = op_e'(host.i_cmd_op);
                            gpio_d  = GPIO_D'(gpio_word(host.i_cmd_op, 1'b0, host.i_cmd_data));
                            cnt_d   = HOLD_LD;
                            state_d = ST_SETUP;
                        end
                        OP_DATA_REQ, OP_RUN: begin
                            op_d    = op_e'(host.i_cmd_op);
                            gpio_d  = GPIO_D'(gpio_word(host.i_cmd_op, 1'b0, 24'd0));
                            cnt_d   = (host.i_cmd_op == OP_RUN) ? TIMEOUT_LD : HOLD_LD;
                            state_d = ST_SETUP;
                        end
                        OP_DUT_RST: begin
                            gpio_d          = '0;
                            gpio_d[RST_BIT] = 1'b1;
                            cnt_d           = RST_LD;
                            state_d         = ST_RST_PULSE;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_SETUP: begin
                gpio_d[VALID_BIT] = 1'b1;
                state_d = (op_q == OP_RUN) ? ST_RUN_WAIT : ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_zero) begin
                    gpio_d[VALID_BIT] = 1'b0;
                    if (op_q == OP_DATA_REQ) begin
                        cnt_d   = RD_LD;
                        state_d = ST_RD_WAIT;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: state_d = ST_IDLE;
            ST_RD_WAIT: begin
                if (cnt_zero) begin
                    rd_data_d  = i_gpio[BITS_DATA-1:0];
                    rd_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN_WAIT: begin
                // Completion is checked first so an edge on the timeout cycle still counts.
                if (eop_rise) begin
                    gpio_d[VALID_BIT] = 1'b0;
                    eop_seen_d        = 1'b1;
                    state_d           = ST_IDLE;
                end else if (cnt_zero) begin
                    gpio_d[VALID_BIT] = 1'b0;
                    err_d             = 1'b1;
                    state_d           = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RST_PULSE: begin
                if (cnt_zero) begin
                    gpio_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_KERNEL;
            cnt_q      <= '0;
            gpio_q     <= GPIO_D'(1);
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            eop_seen_q <= 1'b0;
            err_q      <= 1'b0;
            eop_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            gpio_q     <= gpio_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            eop_seen_q <= eop_seen_d;
            err_q      <= err_d;
            eop_prev_q <= eop_prev_d;
        end
    end

    assign o_gpio           = gpio_q;
    assign host.o_cmd_ready = cmd_ready;
    assign host.o_rd_data   = rd_data_q;
    assign host.o_rd_valid  = rd_valid_q;
    assign host.o_eop_seen  = eop_seen_q;
    assign host.o_err       = err_q;
    assign host.o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpio_host_seq.sv
// Randomized scenario bench for gpio_host_seq against a cycle-count reference model.
module tb_gpio_host_seq;

    localparam int GPIO_D    = 32;
    localparam int BITS_DATA = 13;
    localparam int HOLD      = 2;
    localparam int READ_LAT  = 3;
    localparam int RST_CYC   = 4;
    localparam int TIMEOUT   = 64;

    logic              i_CLK = 1'b0;
    logic              i_rst;
    logic [GPIO_D-1:0] o_gpio;
    logic [GPIO_D-1:0] i_gpio;
    logic              i_eop;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_gpio;

    gpio_host_seq_if #(.BITS_DATA(BITS_DATA)) host ();

    gpio_host_seq #(
        .GPIO_D(GPIO_D), .BITS_DATA(BITS_DATA), .HOLD(HOLD),
        .READ_LAT(READ_LAT), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_CLK (i_CLK),
        .i_rst (i_rst),
        .host  (host),
        .o_gpio(o_gpio),
        .i_gpio(i_gpio),
        .i_eop (i_eop)
    );

    always #5 i_CLK = ~i_CLK;

    // Reference word: ctrl*2^29 + valid*2^28 + data*2
    function automatic logic [31:0] word(input logic [31:0] ctrl, input logic [31:0] valid,
                                         input logic [31:0] data);
        return ctrl * 32'h2000_0000 + valid * 32'h1000_0000 + (data & 32'h00FF_FFFF) * 32'd2;
    endfunction

    // Cycles from accept until ready is high again
    function automatic int latency(input int op);
        if (op <= 2) return HOLD + 3;
        if (op == 3) return HOLD + READ_LAT + 2;
        if (op == 5) return RST_CYC + 1;
        return 1;
    endfunction

    function automatic int pick_op();
        int r;
        r = int'($urandom_range(0, 6));
        return (r >= 4) ? r + 1 : r;
    endfunction

    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic issue(input int op, input int data);
        host.i_cmd_valid = 1'b1;
        host.i_cmd_op    = 3'(op);
        host.i_cmd_data  = 24'(data);
        n_cmp++;
        if (host.o_cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL issue_ready op=%0d: got %b want 1", op, host.o_cmd_ready);
        end
        step();
        host.i_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step();
        step();
        n_cmp++;
        if (o_gpio !== 32'h0000_0001) begin n_err++; $display("FAIL rst_gpio: got %h want 00000001", o_gpio); end
        n_cmp++;
        if ({host.o_cmd_ready, host.o_rd_valid, host.o_eop_seen, host.o_err, host.o_busy} !== 5'b0) begin
            n_err++;
            $display("FAIL rst_flags: got %b want 00000", {host.o_cmd_ready, host.o_rd_valid,
                     host.o_eop_seen, host.o_err, host.o_busy});
        end
        n_cmp++;
        if (host.o_rd_data !== '0) begin n_err++; $display("FAIL rst_rd_data: got %h want 0", host.o_rd_data); end
        i_rst = 1'b0;
        step();
        n_cmp++;
        if (o_gpio !== 32'h0 || host.o_cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_release: got gpio=%h ready=%b want 0/1", o_gpio, host.o_cmd_ready);
        end
        exp_gpio = 32'h0;
    endtask

    task automatic test_write(input int op, input int data);
        logic [31:0] w;
        issue(op, data);
        for (int k = 1; k <= HOLD + 3; k++) begin
            w = word(op, (k >= 2 && k <= HOLD + 1) ? 1 : 0, data);
            n_cmp++;
            if (o_gpio !== w) begin n_err++; $display("FAIL wr_gpio op=%0d k=%0d: got %h want %h", op, k, o_gpio, w); end
            n_cmp++;
            if (host.o_cmd_ready !== (k == HOLD + 3)) begin
                n_err++;
                $display("FAIL wr_ready k=%0d: got %b want %b", k, host.o_cmd_ready, k == HOLD + 3);
            end
            if (k < HOLD + 3) step();
        end
        exp_gpio = word(op, 0, data);
    endtask

    task automatic test_read(input bit hold_const);
        logic [31:0]          w;
        logic [BITS_DATA-1:0] exp_rd;
        int                   last;
        last   = 1 + HOLD + READ_LAT;
        i_gpio = hold_const ? 32'h0000_1ABC : $urandom;
        exp_rd = i_gpio[BITS_DATA-1:0];
        issue(3, int'($urandom));
        for (int k = 1; k <= last + 1; k++) begin
            w = word(3, (k >= 2 && k <= HOLD + 1) ? 1 : 0, 0);
            n_cmp++;
            if (o_gpio !== w) begin n_err++; $display("FAIL rd_gpio k=%0d: got %h want %h", k, o_gpio, w); end
            n_cmp++;
            if (host.o_rd_valid !== (k == last + 1)) begin
                n_err++;
                $display("FAIL rd_valid k=%0d: got %b want %b", k, host.o_rd_valid, k == last + 1);
            end
            if (k == last + 1) begin
                n_cmp++;
                if (host.o_rd_data !== exp_rd || host.o_cmd_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL rd_data: got %h ready=%b want %h ready=1", host.o_rd_data, host.o_cmd_ready, exp_rd);
                end
            end else begin
                if (!hold_const) i_gpio = $urandom;
                if (k == last) exp_rd = i_gpio[BITS_DATA-1:0];
                step();
            end
        end
        step();
        n_cmp++;
        if (host.o_rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_pulse: got %b want 0", host.o_rd_valid); end
        exp_gpio = word(3, 0, 0);
    endtask

    // i_eop rises in RUN_WAIT cycle 'w' (0-based); completion expected the cycle after
    task automatic test_run(input int w);
        int rise_k;
        rise_k = 2 + w;
        i_eop  = 1'b0;
        issue(4, int'($urandom));
        for (int k = 1; k <= rise_k; k++) begin
            n_cmp++;
            if (o_gpio !== word(4, (k >= 2) ? 1 : 0, 0) || host.o_eop_seen !== 1'b0 || host.o_err !== 1'b0) begin
                n_err++;
                $display("FAIL run_wait w=%0d k=%0d: got gpio=%h eop=%b err=%b want %h/0/0", w, k,
                         o_gpio, host.o_eop_seen, host.o_err, word(4, (k >= 2) ? 1 : 0, 0));
            end
            if (k == rise_k) i_eop = 1'b1;
            step();
        end
        n_cmp++;
        if (host.o_eop_seen !== 1'b1 || host.o_err !== 1'b0 || o_gpio !== word(4, 0, 0) || host.o_cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL run_done w=%0d: got eop=%b err=%b gpio=%h ready=%b want 1/0/%h/1", w,
                     host.o_eop_seen, host.o_err, o_gpio, host.o_cmd_ready, word(4, 0, 0));
        end
        i_eop = 1'b0;
        step();
        n_cmp++;
        if (host.o_eop_seen !== 1'b0 || o_gpio !== word(4, 0, 0)) begin
            n_err++;
            $display("FAIL run_after: got eop=%b gpio=%h want 0/%h", host.o_eop_seen, o_gpio, word(4, 0, 0));
        end
        exp_gpio = word(4, 0, 0);
    endtask

    task automatic test_timeout();
        int bad_k;
        bad_k = -1;
        i_eop = 1'b1;
        issue(4, 0);
        for (int k = 1; k < TIMEOUT + 2; k++) begin
            if (bad_k < 0 && (host.o_err !== 1'b0 || host.o_eop_seen !== 1'b0 || host.o_busy !== 1'b1)) bad_k = k;
            step();
        end
        n_cmp++;
        if (bad_k >= 0) begin n_err++; $display("FAIL to_wait: early end at k=%0d want none", bad_k); end
        n_cmp++;
        if (host.o_err !== 1'b1 || host.o_eop_seen !== 1'b0 || o_gpio !== word(4, 0, 0)) begin
            n_err++;
            $display("FAIL to_err: got err=%b eop=%b gpio=%h want 1/0/%h", host.o_err, host.o_eop_seen,
                     o_gpio, word(4, 0, 0));
        end
        i_eop = 1'b0;
        step();
        n_cmp++;
        if (host.o_err !== 1'b0) begin n_err++; $display("FAIL to_err_pulse: got %b want 0", host.o_err); end
        exp_gpio = word(4, 0, 0);
    endtask

    task automatic test_illegal(input int op);
        issue(op, int'($urandom));
        n_cmp++;
        if (host.o_err !== 1'b1 || o_gpio !== exp_gpio || host.o_cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ill_err op=%0d: got err=%b gpio=%h ready=%b want 1/%h/1", op, host.o_err,
                     o_gpio, host.o_cmd_ready, exp_gpio);
        end
        step();
        n_cmp++;
        if (host.o_err !== 1'b0 || o_gpio !== exp_gpio) begin
            n_err++;
            $display("FAIL ill_after: got err=%b gpio=%h want 0/%h", host.o_err, o_gpio, exp_gpio);
        end
    endtask

    task automatic test_dut_rst();
        logic [31:0] w;
        issue(5, int'($urandom));
        for (int k = 1; k <= RST_CYC + 1; k++) begin
            w = (k <= RST_CYC) ? 32'h1 : 32'h0;
            n_cmp++;
            if (o_gpio !== w || host.o_cmd_ready !== (k == RST_CYC + 1)) begin
                n_err++;
                $display("FAIL dutrst k=%0d: got gpio=%h ready=%b want %h/%b", k, o_gpio,
                         host.o_cmd_ready, w, k == RST_CYC + 1);
            end
            if (k <= RST_CYC) step();
        end
        exp_gpio = 32'h0;
    endtask

    task automatic test_rst_mid();
        bit stray;
        stray = 1'b0;
        issue(3, 0);
        step();
        i_rst = 1'b1;
        step();
        n_cmp++;
        if (o_gpio !== 32'h1 || {host.o_rd_valid, host.o_err, host.o_busy, host.o_cmd_ready} !== 4'b0) begin
            n_err++;
            $display("FAIL mid_rst: got gpio=%h flags=%b want 00000001/0000", o_gpio,
                     {host.o_rd_valid, host.o_err, host.o_busy, host.o_cmd_ready});
        end
        i_rst = 1'b0;
        step();
        n_cmp++;
        if (o_gpio !== 32'h0 || host.o_cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_release: got gpio=%h ready=%b want 0/1", o_gpio, host.o_cmd_ready);
        end
        for (int k = 0; k < HOLD + READ_LAT + 4; k++) begin
            if (host.o_rd_valid !== 1'b0 || host.o_err !== 1'b0) stray = 1'b1;
            step();
        end
        n_cmp++;
        if (stray) begin n_err++; $display("FAIL mid_stray: got a pulse want none"); end
        exp_gpio = 32'h0;
    endtask

    task automatic test_back_to_back(input int n);
        int op, prev, cyc, reads, rd_seen;
        reads   = 0;
        rd_seen = 0;
        op      = pick_op();
        host.i_cmd_valid = 1'b1;
        host.i_cmd_op    = 3'(op);
        host.i_cmd_data  = 24'($urandom);
        for (int i = 0; i < n; i++) begin
            if (op == 3) reads++;
            step();
            cyc = 1;
            if (host.o_rd_valid === 1'b1) rd_seen++;
            prev = op;
            op   = pick_op();
            host.i_cmd_op   = 3'(op);
            host.i_cmd_data = 24'($urandom);
            i_gpio          = $urandom;
            while (host.o_cmd_ready !== 1'b1 && cyc < 100) begin
                step();
                cyc++;
                if (host.o_rd_valid === 1'b1) rd_seen++;
            end
            n_cmp++;
            if (cyc !== latency(prev)) begin
                n_err++;
                $display("FAIL b2b_lat i=%0d op=%0d: got %0d cycles want %0d", i, prev, cyc, latency(prev));
            end
        end
        host.i_cmd_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (host.o_rd_valid === 1'b1) rd_seen++;
        end
        n_cmp++;
        if (rd_seen !== reads) begin n_err++; $display("FAIL b2b_reads: got %0d pulses want %0d", rd_seen, reads); end
    endtask

    initial begin
        i_rst            = 1'b1;
        i_eop            = 1'b0;
        i_gpio           = '0;
        host.i_cmd_valid = 1'b0;
        host.i_cmd_op    = '0;
        host.i_cmd_data  = '0;
        exp_gpio         = 32'h0;
        test_reset();
        test_write(0, 32'h0012_3456);
        repeat (4) test_write(int'($urandom_range(0, 2)), int'($urandom));
        test_read(1'b1);
        repeat (3) test_read(1'b0);
        test_run(TIMEOUT - 1);
        test_run(0);
        repeat (3) test_run(int'($urandom_range(1, TIMEOUT - 2)));
        test_timeout();
        test_write(int'($urandom_range(0, 2)), int'($urandom) | 1);
        test_illegal(7);
        test_illegal(6);
        test_dut_rst();
        test_rst_mid();
        test_back_to_back(30);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish before 300000");
        $fatal(1, "watchdog expired");
    end

endmodule
